// File: rtl/flit_pattern_injector.sv
// Purpose: injects 2N-bit test flits (walking-ones patterns) in packets of PAYLOAD flits separated by GAP idle cycles.
// Latency: registered outputs; valid rises the cycle after start is sampled in IDLE, done pulses one cycle after the last gap.
// Backpressure: valid/ready; the flit, sof and eof hold while ready is low. Optional INJ_ACTIVITY_CNT_EN adds the toggle counter.
module flit_pattern_injector #(
    parameter int N       = 22,
    parameter int PAYLOAD = 20,
    parameter int GAP     = 7,
    parameter int NUM_PKT = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ready,
    output logic          valid,
    output logic [N-1:0]  op_a,
    output logic [N-1:0]  op_b,
    output logic          sof,
    output logic          eof,
    output logic          busy,
    output logic          done,
    output logic [31:0]   act_cnt
);

    localparam int            W      = 2 * N;
    localparam int            KW     = $clog2(W + 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW-1:0] K_MAX  = KW'(W);
    localparam logic [7:0]    PAY_L  = 8'(PAYLOAD);
    localparam logic [7:0]    GAP_M1 = (GAP == 0) ? 8'd0 : 8'(GAP - 1);
    localparam logic [7:0]    NPK_L  = 8'(NUM_PKT);
    localparam bit            FINITE = (NUM_PKT != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [1:0]    ph_q, ph_d;
    logic [7:0]    flit_q, flit_d;
    logic [7:0]    pkt_q, pkt_d;
    logic [7:0]    gap_q, gap_d;
    logic [W-1:0]  word_q, word_d;
    logic          sof_q, sof_d;
    logic          eof_q, eof_d;

    logic          xfer;
    logic          run_start;
    logic          load_first;
    logic [KW-1:0] k_adv;
    logic [1:0]    ph_adv;

    // LOW(k) is k least-significant ones; phase 2 swaps the two halves of it.
    function automatic logic [W-1:0] pattern(input logic [KW-1:0] k, input logic [1:0] ph);
        logic [W-1:0] low;
        low = ~({W{1'b1}} << k);
        case (ph)
            2'd0:    pattern = low;
            2'd1:    pattern = ~low;
            default: pattern = {low[N-1:0], low[W-1:N]};
        endcase
    endfunction

    assign xfer      = (state_q == S_SEND) && ready;
    assign run_start = (state_q == S_IDLE) && start;

    // Sequencing: next state, flit/packet/gap counters and the next registered flit.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        ph_d       = ph_q;
        flit_d     = flit_q;
        pkt_d      = pkt_q;
        gap_d      = gap_q;
        word_d     = word_q;
        sof_d      = sof_q;
        eof_d      = eof_q;
        load_first = 1'b0;
        ph_adv     = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
        k_adv      = (ph_q != 2'd2) ? k_q : ((k_q == K_MAX) ? K_ONE : k_q + K_ONE);

        case (state_q)
            S_IDLE: begin
                if (run_start) begin
                    state_d    = S_SEND;
                    pkt_d      = 8'd0;
                    load_first = 1'b1;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (flit_q == PAY_L) begin
                        pkt_d = pkt_q + 8'd1;
                        if (GAP != 0) begin
                            state_d = S_GAP;
                            gap_d   = 8'd0;
                            word_d  = '0;
                            sof_d   = 1'b0;
                            eof_d   = 1'b0;
                        end else if (FINITE && (pkt_q + 8'd1 == NPK_L)) begin
                            state_d = S_DONE;
                            word_d  = '0;
                            sof_d   = 1'b0;
                            eof_d   = 1'b0;
                        end else begin
                            load_first = 1'b1;
                        end
                    end else begin
                        flit_d = flit_q + 8'd1;
                        k_d    = k_adv;
                        ph_d   = ph_adv;
                        word_d = pattern(k_adv, ph_adv);
                        sof_d  = 1'b0;
                        eof_d  = (flit_q + 8'd1 == PAY_L);
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_M1) begin
                    if (FINITE && (pkt_q == NPK_L)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_SEND;
                        load_first = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every packet restarts the pattern at k=1, ph=0.
        if (load_first) begin
            flit_d = 8'd1;
            k_d    = K_ONE;
            ph_d   = 2'd0;
            word_d = pattern(K_ONE, 2'd0);
            sof_d  = 1'b1;
            eof_d  = (PAY_L == 8'd1);
        end
    end

    // State and datapath registers; reset wins over start and ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= K_ONE;
            ph_q    <= 2'd0;
            flit_q  <= 8'd0;
            pkt_q   <= 8'd0;
            gap_q   <= 8'd0;
            word_q  <= '0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ph_q    <= ph_d;
            flit_q  <= flit_d;
            pkt_q   <= pkt_d;
            gap_q   <= gap_d;
            word_q  <= word_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
        end
    end

    assign valid = (state_q == S_SEND);
    assign busy  = (state_q == S_SEND) || (state_q == S_GAP);
    assign done  = (state_q == S_DONE);
    assign op_a  = word_q[N-1:0];
    assign op_b  = word_q[W-1:N];
    assign sof   = sof_q;
    assign eof   = eof_q;

`ifdef INJ_ACTIVITY_CNT_EN
    logic [W-1:0] prev_q, prev_d;
    logic [31:0]  act_q, act_d;
    logic [W-1:0] diff;
    logic [31:0]  pop;
    logic [32:0]  sum;

    // Toggle activity: bits changed versus the previously transferred word, saturating.
    always_comb begin
        prev_d = prev_q;
        act_d  = act_q;
        diff   = word_q ^ prev_q;
        pop    = 32'd0;
        for (int i = 0; i < W; i++) begin
            pop = pop + {31'd0, diff[i]};
        end
        sum = {1'b0, act_q} + {1'b0, pop};
        if (run_start) begin
            prev_d = '0;
            act_d  = 32'd0;
        end else if (xfer) begin
            prev_d = word_q;
            act_d  = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
        end
    end

    // Activity registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            act_q  <= 32'd0;
        end else begin
            prev_q <= prev_d;
            act_q  <= act_d;
        end
    end

    assign act_cnt = act_q;
`else
    assign act_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_flit_pattern_injector.sv
// Purpose: self-checking bench for flit_pattern_injector (defaults, GAP=0 and PAYLOAD=3 instances).
// Latency: expected flits are queued at start and compared as each transfer happens.
// Backpressure: stalls ready for three cycles mid-packet and checks the held flit.
module tb_flit_pattern_injector;

    localparam int N = 22;
    localparam int W = 2 * N;
`ifdef INJ_ACTIVITY_CNT_EN
    localparam logic [31:0] ACT_EXP = 32'd87;
`else
    localparam logic [31:0] ACT_EXP = 32'd0;
`endif

    typedef struct packed {
        logic [W-1:0] w;
        logic         s;
        logic         e;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, ready;
    logic          valid, sof, eof, busy, done;
    logic [N-1:0]  op_a, op_b;
    logic [31:0]   act_cnt;

    logic          start_g, ready_g;
    logic          valid_g, sof_g, eof_g, busy_g, done_g;
    logic [N-1:0]  op_a_g, op_b_g;
    logic [31:0]   act_cnt_g;

    logic          start_p, ready_p;
    logic          valid_p, sof_p, eof_p, busy_p, done_p;
    logic [N-1:0]  op_a_p, op_b_p;
    logic [31:0]   act_cnt_p;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic reached;

    flit_pattern_injector dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .valid(valid), .op_a(op_a), .op_b(op_b), .sof(sof), .eof(eof),
        .busy(busy), .done(done), .act_cnt(act_cnt)
    );

    flit_pattern_injector #(.GAP(0), .NUM_PKT(2)) dut_g (
        .clk(clk), .rst(rst), .start(start_g), .ready(ready_g),
        .valid(valid_g), .op_a(op_a_g), .op_b(op_b_g), .sof(sof_g), .eof(eof_g),
        .busy(busy_g), .done(done_g), .act_cnt(act_cnt_g)
    );

    flit_pattern_injector #(.PAYLOAD(3), .NUM_PKT(1)) dut_p (
        .clk(clk), .rst(rst), .start(start_p), .ready(ready_p),
        .valid(valid_p), .op_a(op_a_p), .op_b(op_b_p), .sof(sof_p), .eof(eof_p),
        .busy(busy_p), .done(done_p), .act_cnt(act_cnt_p)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference flit for 0-based position idx within a packet.
    function automatic logic [W-1:0] model_word(input int idx);
        int ph;
        int k;
        logic [W-1:0] low;
        ph  = idx % 3;
        k   = ((idx / 3) % W) + 1;
        low = '0;
        for (int i = 0; i < k; i++) low[i] = 1'b1;
        case (ph)
            0:       return low;
            1:       return ~low;
            default: return (low << N) | (low >> N);
        endcase
    endfunction

    task automatic push_run(input int payload, input int npkt);
        exp_t e;
        for (int p = 0; p < npkt; p++) begin
            for (int f = 0; f < payload; f++) begin
                e.w = model_word(f);
                e.s = (f == 0);
                e.e = (f == payload - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One default-parameter run on dut; optional stall at flit stall_at, optional reset once stop_xf flits moved.
    task automatic run_main(input int stall_at, input int stop_xf, input int done_exp, input int ncyc);
        int          xf;
        int          stall_rem;
        int          done_seen;
        bit          used;
        logic [63:0] held;
        logic [63:0] cur;
        exp_t        e;
        xf = 0; stall_rem = 0; done_seen = 0; used = 1'b0; held = '0;
        reached = 1'b0;
        push_run(20, 10);
        start = 1'b1;
        ready = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            start = 1'b0;
            ready = 1'b1;
            cur = {18'd0, op_b, op_a, sof, eof};
            if (stop_xf > 0 && valid && xf == stop_xf) begin
                reached = 1'b1;
                rst = 1'b1;
                break;
            end
            if (stall_at > 0 && valid && !used && xf == stall_at - 1) begin
                used = 1'b1;
                stall_rem = 3;
                held = cur;
            end
            if (stall_rem > 0) begin
                ready = 1'b0;
                if (stall_rem < 3) begin
                    chk("stall_hold", cur, held);
                    chk("stall_valid", valid, 1);
                end
                stall_rem--;
            end
            if (stall_at == 0 && stop_xf == 0) begin
                chk("valid_win", valid, (c <= 270 && (c - 1) % 27 < 20));
                chk("busy_win", busy, (c <= 270));
            end
            if (valid && ready) begin
                chk("sb_avail", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("flit", cur, {18'd0, e.w, e.s, e.e});
                end
                if (xf == 0) chk("flit1_const", {op_b, op_a, sof}, {22'h000000, 22'h000001, 1'b1});
                if (xf == 1) chk("flit2_const", {op_b, op_a}, {22'h3FFFFF, 22'h3FFFFE});
                if (xf == 2) chk("flit3_const", {op_b, op_a}, {22'h000001, 22'h000000});
                xf++;
            end
            if (done) begin
                done_seen++;
                chk("done_cycle", c, done_exp);
            end
        end
        if (stop_xf > 0) begin
            chk("stop_reached", reached, 1);
        end else begin
            chk("xfer_total", xf, 200);
            chk("done_count", done_seen, 1);
            chk("sb_empty", sb.size(), 0);
        end
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; start = 1'b1; ready = 1'b1;
        start_g = 1'b0; ready_g = 1'b1;
        start_p = 1'b0; ready_p = 1'b1;

        // Reset held two cycles with start asserted.
        tick();
        tick();
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_sof_eof", {sof, eof}, 0);
        chk("rst_act", act_cnt, 0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_valid", valid, 0);

        // Full default run, then one with a three-cycle stall on flit 5.
        run_main(0, 0, 271, 280);
        run_main(5, 0, 274, 285);

        // Reset at flit 10 of packet 3, then a fresh run.
        run_main(0, 49, 0, 100);
        tick();
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_op", {op_b, op_a}, 0);
        chk("mid_rst_sof_eof", {sof, eof}, 0);
        rst = 1'b0;
        sb.delete();
        run_main(0, 0, 271, 280);

        // GAP=0, NUM_PKT=2: forty back-to-back flits then done.
        push_run(20, 2);
        start_g = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            tick();
            start_g = 1'b0;
            chk("g0_valid", valid_g, (c <= 40));
            if (valid_g) begin
                chk("g0_sb_avail", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("g0_flit", {18'd0, op_b_g, op_a_g, sof_g, eof_g}, {18'd0, e.w, e.s, e.e});
                end
            end
            chk("g0_done", done_g, (c == 41));
        end
        chk("g0_sb_empty", sb.size(), 0);

        // PAYLOAD=3, NUM_PKT=1 activity count; second run checks clear-on-start.
        for (int r = 0; r < 2; r++) begin
            start_p = 1'b1;
            for (int c = 1; c <= 12; c++) begin
                tick();
                start_p = 1'b0;
                if (c == 1 && r == 1) chk("act_cleared", act_cnt_p, 0);
                chk("p3_valid", valid_p, (c <= 3));
                chk("p3_done", done_p, (c == 11));
                if (c == 11) chk("act_at_done", act_cnt_p, ACT_EXP);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flit_pattern_injector.md
FLIT_PATTERN_INJECTOR -- requirements
Module: flit_pattern_injector

Interface
REQ-001 Parameter N, default 22: operand width; the injected flit word is 2N bits.
REQ-002 Parameter PAYLOAD, default 20: flits per packet, range 1..255.
REQ-003 Parameter GAP, default 7: idle cycles after each packet, range 0..255.
REQ-004 Parameter NUM_PKT, default 10: packets per run; 0 means run until reset.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all logic is rising-edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 start  in  1  begins a run; sampled only in IDLE.
REQ-009 ready  in  1  downstream adder stage accepts the flit.
REQ-010 valid  out  1  op_a and op_b hold a flit.
REQ-011 op_a  out  N  low half of the flit word (word[N-1:0]).
REQ-012 op_b  out  N  high half of the flit word (word[2N-1:N]).
REQ-013 sof / eof  out  1 each  first / last flit of the packet, qualified by valid.
REQ-014 busy  out  1  high in the SEND and GAP states.
REQ-015 done  out  1  one-cycle pulse at the end of a run.
REQ-016 act_cnt  out  32  accumulated bit-toggle count (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, SEND, GAP and DONE, with these transitions:
- IDLE->SEND on start.
- SEND->GAP on the transfer of flit PAYLOAD.
- GAP->SEND after GAP cycles if packets remain.
- GAP->DONE after GAP cycles if the run is complete.
- DONE->IDLE after one cycle.
REQ-018 When GAP=0, SEND SHALL go directly to SEND (next packet) or to DONE, with no idle cycle.
REQ-019 A transfer SHALL occur on a cycle with valid&&ready; the flit counter and pattern advance only on a transfer.
REQ-020 While valid&&!ready, op_a, op_b, sof and eof SHALL stay stable.
REQ-021 valid SHALL be 1 exactly in SEND; outputs are registered, so valid rises the cycle after start is sampled.
REQ-022 Pattern state SHALL be a step index k in 1..2N and a phase ph in 0..2, with LOW(k) = k least-significant ones:
- ph0: word = LOW(k).
- ph1: word = ~LOW(k).
- ph2: word = LOW(k) rotated left by N.
REQ-023 ph SHALL advance 0->1->2->0; k SHALL increment when ph wraps; k SHALL wrap from 2N to 1.
REQ-024 The pattern SHALL restart at k=1, ph=0 at the first flit of every packet.
REQ-025 sof SHALL be 1 on flit 1 and eof on flit PAYLOAD; both are 1 when PAYLOAD=1.
REQ-026 The packet counter SHALL be 8 bits; with NUM_PKT=0 it is not compared and the run never reaches DONE.
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 When ready is 0 on the eof flit, SEND SHALL hold until that flit transfers.

Reset
REQ-029 On rst the block SHALL enter IDLE with these values on the next edge:
- valid, sof, eof, busy, done = 0.
- op_a, op_b = 0.
- act_cnt = 0.
- k=1, ph=0, all counters 0.
REQ-030 rst SHALL take priority over start and ready, including mid-packet; an in-flight flit is discarded without transfer.

Configuration
REQ-031 With macro INJ_ACTIVITY_CNT_EN defined, act_cnt SHALL behave as follows:
- On each transfer, add popcount(word XOR previous transferred word).
- Previous word is 0 after rst or start.
- Clear on start.
- Saturate at 32'hFFFFFFFF.
REQ-032 Without INJ_ACTIVITY_CNT_EN, act_cnt SHALL be tied to 0 and no popcount logic is instantiated.

Verification
REQ-033 Assert rst for 2 cycles with start=1 -> valid=0, busy=0, done=0, op_a=op_b=0.
REQ-034 Defaults, ready=1, start pulsed at cycle 0 -> check:
- Flit 1: op_a=22'h000001, op_b=22'h000000, sof=1.
- Flit 2: op_a=22'h3FFFFE, op_b=22'h3FFFFF.
- Flit 3: op_a=22'h000000, op_b=22'h000001.
- Valid in cycles 1-20, 28-47, and so on.
- 200 transfers total; done=1 in cycle 271 only.
REQ-035 Drop ready for 3 cycles at flit 5 -> flit 5 held stable, no extra flits, eof still on flit 20.
REQ-036 GAP=0, NUM_PKT=2 -> 40 consecutive valid cycles, sof on flits 1 and 21, eof on flits 20 and 40, then done.
REQ-037 Assert rst at flit 10 of packet 3 -> IDLE next cycle; a new start gives flit 1 = 22'h000001 with sof=1.
REQ-038 INJ_ACTIVITY_CNT_EN defined, PAYLOAD=3, NUM_PKT=1 -> act_cnt=87 (1+44+42) at done.
